// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan driver.
//   SEG_BLANK      all segments dark (active-low)
//   SEG_0..SEG_F   hex glyphs {a,b,c,d,e,f,g,dp}, active-low, dp off
//   SCAN_Q7..Q4    scan index codes driven on enable
//   seg_lut()      nibble -> glyph lookup
package ssd_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'hC1;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h85;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_F = 8'h71;

  localparam logic [1:0] SCAN_Q7 = 2'b00;
  localparam logic [1:0] SCAN_Q6 = 2'b01;
  localparam logic [1:0] SCAN_Q5 = 2'b10;
  localparam logic [1:0] SCAN_Q4 = 2'b11;

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = SEG_0;
      4'h1: seg_lut = SEG_1;
      4'h2: seg_lut = SEG_2;
      4'h3: seg_lut = SEG_3;
      4'h4: seg_lut = SEG_4;
      4'h5: seg_lut = SEG_5;
      4'h6: seg_lut = SEG_6;
      4'h7: seg_lut = SEG_7;
      4'h8: seg_lut = SEG_8;
      4'h9: seg_lut = SEG_9;
      4'hA: seg_lut = SEG_A;
      4'hB: seg_lut = SEG_B;
      4'hC: seg_lut = SEG_C;
      4'hD: seg_lut = SEG_D;
      4'hE: seg_lut = SEG_E;
      default: seg_lut = SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex-nibble to active-low segment encoder.
//   i_nibble  hex digit
//   i_dp      decimal point lit (clears bit 0)
//   i_blank   force segments a..g dark; dp still follows i_dp
//   o_seg     {a,b,c,d,e,f,g,dp}, active-low
module hex_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);
  logic [7:0] w_raw;
  logic [7:0] w_blank;

  assign w_raw   = seg_lut(i_nibble);
  assign w_blank = SEG_BLANK;
  assign o_seg   = {(i_blank ? w_blank[7:1] : w_raw[7:1]), ~i_dp};
endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: four-digit seven-segment scan driver.
//   clk, rst_n     clock, async active-low reset
//   load_valid/ready  handshake for a new display value
//   digit_in       four nibbles, [15:12] -> q_7 ... [3:0] -> q_4
//   dp_in          decimal points, [3] -> q_7 ... [0] -> q_4
//   blank_lead     suppress leading zeros on q_7..q_5
//   enable         scan index, 00=q_7 .. 11=q_4
//   q_7..q_4       registered active-low segment patterns
//   frame_tick     one-cycle pulse after each frame boundary
// New values wait in a single pending register and are committed only at
// a frame boundary so a frame never mixes old and new digits.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digit_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lead,
  output logic [1:0]  enable,
  output logic [7:0]  q_7,
  output logic [7:0]  q_6,
  output logic [7:0]  q_5,
  output logic [7:0]  q_4,
  output logic        frame_tick
);
  logic [DIV_W-1:0] r_presc;
  logic [1:0]       r_enable;
  logic             r_frame_tick;
  logic             r_pend_v;
  logic [15:0]      r_pend_digit;
  logic [3:0]       r_pend_dp;
  logic             r_pend_bl;
  logic [3:0][7:0]  r_q;

  logic             w_tick;
  logic             w_boundary;
  logic             w_accept;
  logic             w_commit;
  logic [3:0][3:0]  w_nib;
  logic [3:0]       w_blank;
  logic [3:0][7:0]  w_seg;

  assign w_tick     = &r_presc;
  assign w_boundary = w_tick && (r_enable == SCAN_Q4);
  assign w_accept   = load_valid && !r_pend_v;
  // Commit uses the pend_v seen before this edge; a same-cycle accept
  // only becomes pending and waits for the next boundary.
  assign w_commit   = w_boundary && r_pend_v;

  // Index 3 is the leftmost digit (q_7).
  assign w_nib = r_pend_digit;

  // Leading-zero chain: a digit blanks only if every digit to its left
  // also blanked. The rightmost digit always shows.
  assign w_blank[3] = r_pend_bl && (w_nib[3] == 4'h0);
  assign w_blank[2] = w_blank[3] && (w_nib[2] == 4'h0);
  assign w_blank[1] = w_blank[2] && (w_nib[1] == 4'h0);
  assign w_blank[0] = 1'b0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_enc
    hex_to_seg u_enc (
      .i_nibble (w_nib[gi]),
      .i_dp     (r_pend_dp[gi]),
      .i_blank  (w_blank[gi]),
      .o_seg    (w_seg[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_enable     <= SCAN_Q7;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc      <= r_presc + {{(DIV_W-1){1'b0}}, 1'b1};
      r_frame_tick <= w_boundary;
      if (w_tick) r_enable <= r_enable + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v     <= 1'b0;
      r_pend_digit <= '0;
      r_pend_dp    <= '0;
      r_pend_bl    <= 1'b0;
      r_q          <= {4{SEG_BLANK}};
    end else begin
      if (w_accept) begin
        r_pend_v     <= 1'b1;
        r_pend_digit <= digit_in;
        r_pend_dp    <= dp_in;
        r_pend_bl    <= blank_lead;
      end else if (w_commit) begin
        r_pend_v <= 1'b0;
      end
      if (w_commit) r_q <= w_seg;
    end
  end

  assign load_ready = !r_pend_v;
  assign enable     = r_enable;
  assign frame_tick = r_frame_tick;
  assign q_7        = r_q[3];
  assign q_6        = r_q[2];
  assign q_5        = r_q[1];
  assign q_4        = r_q[0];
endmodule
